// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the sequential approximate multiplier.
// Optional feature macro: APPROX_COMP_EN (mean-error compensation constant).
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Column mask over a 64-bit field: bits [trunc-1:0] are zero, bits
  // [width-1:trunc] are one, everything at or above width is zero.
  function automatic logic [63:0] trunc_mask(input int unsigned trunc,
                                             input int unsigned width);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= trunc && i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Half of the weight of the dropped columns: 2^(trunc-1), or 0 when
  // nothing is truncated.
  function automatic logic [63:0] comp_const(input int unsigned trunc);
    if (trunc == 0) return '0;
    return 64'(1) << (trunc - 1);
  endfunction

endpackage

// File: rtl/approx_pp_row.sv
// Combinational partial-product row: the shifted multiplicand gated by the
// current multiplier bit, with low columns cleared in approximate mode.
module approx_pp_row
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 8
) (
  input  logic [2*WIDTH-1:0] acc_a_i,
  input  logic               sb0_i,
  input  logic               mode_i,
  output logic [2*WIDTH-1:0] row_o
);

  localparam int unsigned  PW        = 2 * WIDTH;
  localparam logic [63:0]  MASK_FULL = trunc_mask(TRUNC, PW);

  logic [PW-1:0] mask_c;
  assign mask_c = MASK_FULL[PW-1:0];

  // Select zero, the full row, or the truncated row.
  always_comb begin
    row_o = '0;
    if (sb0_i) begin
      row_o = mode_i ? (acc_a_i & mask_c) : acc_a_i;
    end
  end

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-and-add unsigned multiplier with per-operation
// truncation of low product columns and early termination once the
// remaining multiplier bits are zero. Valid/ready on both sides.
// Optional feature macro: APPROX_COMP_EN adds 2^(TRUNC-1) to approximate
// results with a nonzero multiplier.
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  state_e         state_q;
  logic [PW-1:0]  acc_a_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sb_d;
  logic           mode_q;
  logic [PW-1:0]  acc_q;
  logic [PW-1:0]  acc_d;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  result_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [PW-1:0]  row_c;
  logic           last_c;

`ifdef APPROX_COMP_EN
  localparam logic [63:0] COMP_FULL = comp_const(TRUNC);
  logic          nz_q;
  logic [PW-1:0] comp_c;
  assign comp_c = COMP_FULL[PW-1:0];
`endif

  approx_pp_row #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_row (
    .acc_a_i (acc_a_q),
    .sb0_i   (sb_q[0]),
    .mode_i  (mode_q),
    .row_o   (row_c)
  );

  // Next accumulator, next multiplier shift and the last-row decision.
  always_comb begin
    sb_d   = sb_q >> 1;
    last_c = (sb_d == '0) || (cnt_q == CW'(WIDTH - 1));
    acc_d  = acc_q + row_c;
`ifdef APPROX_COMP_EN
    // Compensation is folded into the final CALC cycle so it costs no
    // extra latency.
    if (last_c && mode_q && nz_q) acc_d = acc_d + comp_c;
`endif
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      acc_a_q     <= '0;
      sb_q        <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef APPROX_COMP_EN
      nz_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_a_q    <= PW'(a);
            sb_q       <= b;
            mode_q     <= approx_en;
`ifdef APPROX_COMP_EN
            nz_q       <= (b != '0);
`endif
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (last_c) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q   <= acc_d;
            acc_a_q <= acc_a_q << 1;
            sb_q    <= sb_d;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed self-checking bench for approx_mul_seq at WIDTH=8, TRUNC=8.
// Expected approximate results follow APPROX_COMP_EN when it is defined.
module tb_approx_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        approx_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef APPROX_COMP_EN
  localparam logic [31:0] EXP_APPROX_FF = 32'd63360;
  localparam logic [31:0] EXP_APPROX_ET = 32'd384;
`else
  localparam logic [31:0] EXP_APPROX_FF = 32'd63232;
  localparam logic [31:0] EXP_APPROX_ET = 32'd256;
`endif

  always #5 clk = ~clk;

  approx_mul_seq #(
    .WIDTH (8),
    .TRUNC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present operands and complete the accept edge; returns #1 after it.
  task automatic start_op(input string tag, input logic [7:0] av,
                          input logic [7:0] bv, input logic m);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rdy"}, in_ready, 1);
    a = av;
    b = bv;
    approx_en = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
  endtask

  // Count rising edges after the accept edge until out_valid appears.
  task automatic wait_result(output logic [15:0] res, output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    res = result;
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_ovld_drop"}, out_valid, 0);
    check({tag, "_rdy_after"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] av,
                        input logic [7:0] bv, input logic m,
                        input logic [31:0] exp_res, input int exp_k);
    logic [15:0] res;
    int          edges;
    start_op(tag, av, bv, m);
    wait_result(res, edges);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_lat"}, edges, exp_k);
    finish_op(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] res;
    int          edges;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ovld", out_valid, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_rdy", in_ready, 1);

    // a, b, mode, expected result, CALC cycles (msb index of b + 1, min 1).
    run_op("exact_ff", 8'd255, 8'd255, 1'b0, 32'd65025, 8);
    run_op("apprx_ff", 8'd255, 8'd255, 1'b1, EXP_APPROX_FF, 8);
    run_op("exact_et", 8'd200, 8'd3, 1'b0, 32'd600, 2);
    run_op("apprx_et", 8'd200, 8'd3, 1'b1, EXP_APPROX_ET, 2);
    run_op("zero_b", 8'd77, 8'd0, 1'b1, 32'd0, 1);
    run_op("exact_mid", 8'd13, 8'd11, 1'b0, 32'd143, 4);

    // Backpressure: result held, ignored operand pulses while busy.
    start_op("bp", 8'd100, 8'd100, 1'b0);
    wait_result(res, edges);
    check("bp_res", res, 10000);
    check("bp_lat", edges, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      a = 8'd1;
      b = 8'd1;
      @(posedge clk);
      #1;
      check("bp_hold_res", result, 10000);
      check("bp_hold_ovld", out_valid, 1);
      check("bp_hold_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    finish_op("bp");
    repeat (3) @(posedge clk);
    #1 check("bp_no_ghost", out_valid, 0);
    run_op("bp_next", 8'd2, 8'd2, 1'b0, 32'd4, 2);

    // Reset during the 4th CALC cycle of 255*255.
    start_op("rmid", 8'd255, 8'd255, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("rmid_ovld", out_valid, 0);
    check("rmid_result", result, 0);
    check("rmid_rdy", in_ready, 1);
    repeat (10) @(posedge clk);
    #1 check("rmid_quiet", out_valid, 0);
    run_op("post_rst", 8'd3, 8'd5, 1'b0, 32'd15, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
